// File: rtl/dmem_responder.sv
// Single-port data memory slave with a fixed number of wait states per access.
// Supports word and zero-extended byte loads/stores; misaligned word accesses report MemErr.
module dmem_responder #(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReq,
  input  logic        MemWrite,
  input  logic        ByteMode,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        MemReady,
  output logic        MemErr,
  output logic        Busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic accept, fire;

  logic [AW+1:0] addr_p0;
  logic [31:0]   wdata_p0;
  logic          write_p0;
  logic          byte_p0;

  logic [AW+1:0] op_addr;
  logic [31:0]   op_wdata;
  logic          op_write;
  logic          op_byte;
  logic [AW-1:0] op_idx;
  logic [1:0]    op_lane;
  logic          op_err;

  logic [31:0] mem [DEPTH];

  // Address bits above the array size alias onto the same words.
  logic addr_unused;
  assign addr_unused = &{1'b0, Addr[31:AW+2]};

  function automatic logic [31:0] load_value(input logic [31:0] word,
                                             input logic [1:0]  lane,
                                             input logic        is_byte);
    if (is_byte) return {24'd0, word[8*lane +: 8]};
    return word;
  endfunction

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    fire      = 1'b0;
    case (state)
      IDLE: begin
        if (MemReq) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_nxt = RESP;
            fire      = 1'b1;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = WAIT_INIT;
          end
        end
      end
      WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_nxt = RESP;
          fire      = 1'b1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // With zero wait states the access completes on the accepting edge, so use live inputs.
  always_comb begin
    if (state == IDLE) begin
      op_addr  = Addr[AW+1:0];
      op_wdata = WriteData;
      op_write = MemWrite;
      op_byte  = ByteMode;
    end else begin
      op_addr  = addr_p0;
      op_wdata = wdata_p0;
      op_write = write_p0;
      op_byte  = byte_p0;
    end
  end

  assign op_idx  = op_addr[AW+1:2];
  assign op_lane = op_addr[1:0];
  assign op_err  = !op_byte && (op_addr[1:0] != 2'b00);

  // Stage p0: request capture at acceptance
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_p0  <= Addr[AW+1:0];
      wdata_p0 <= WriteData;
      write_p0 <= MemWrite;
      byte_p0  <= ByteMode;
    end
  end

  // Stage p1: array update on the edge entering RESP
  always_ff @(posedge clk) begin
    if (fire && op_write && !op_err) begin
      if (op_byte) mem[op_idx][8*op_lane +: 8] <= op_wdata[7:0];
      else         mem[op_idx] <= op_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      ReadData <= 32'd0;
      MemErr   <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      MemErr <= fire && op_err;
      if (fire) begin
        if (op_err)         ReadData <= 32'd0;
        else if (!op_write) ReadData <= load_value(mem[op_idx], op_lane, op_byte);
      end
    end
  end

  assign MemReady = (state == RESP);
  assign Busy     = (state != IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (DEPTH=64, WAIT_CYCLES=2).
// Response latency is counted with the accepting edge as edge 1.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemReq;
  logic        MemWrite;
  logic        ByteMode;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        MemReady;
  logic        MemErr;
  logic        Busy;

  int checks = 0;
  int errors = 0;

  int          r_edges;
  logic [31:0] r_rdata;
  logic        r_err;
  logic        r_busy;
  logic        r_ready_after;

  dmem_responder #(.DEPTH(64), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .MemReq(MemReq), .MemWrite(MemWrite),
    .ByteMode(ByteMode), .Addr(Addr), .WriteData(WriteData),
    .ReadData(ReadData), .MemReady(MemReady), .MemErr(MemErr), .Busy(Busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic do_req(input logic w, input logic b, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    MemReq = 1'b1; MemWrite = w; ByteMode = b; Addr = a; WriteData = d;
    @(posedge clk); #1;
    MemReq  = 1'b0;
    r_edges = 1;
    r_busy  = Busy;
    while (MemReady !== 1'b1 && r_edges < 20) begin
      @(posedge clk); #1;
      r_edges++;
    end
    r_rdata = ReadData;
    r_err   = MemErr;
    @(posedge clk); #1;
    r_ready_after = MemReady;
  endtask

  task automatic test_reset;
    reset = 1'b1; MemReq = 1'b0; MemWrite = 1'b0; ByteMode = 1'b0; Addr = '0; WriteData = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (ReadData !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %h want %h", ReadData, 32'd0); end
    checks++; if (MemReady !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", MemReady); end
    checks++; if (MemErr !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", MemErr); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", Busy); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_word;
    do_req(1'b1, 1'b0, 32'h10, 32'hDEADBEEF);
    checks++; if (r_edges !== 3) begin errors++; $display("FAIL word_st_latency: got %0d want 3", r_edges); end
    checks++; if (r_busy !== 1'b1) begin errors++; $display("FAIL word_st_busy: got %b want 1", r_busy); end
    checks++; if (r_err !== 1'b0) begin errors++; $display("FAIL word_st_err: got %b want 0", r_err); end
    checks++; if (r_ready_after !== 1'b0) begin errors++; $display("FAIL word_st_ready_pulse: got %b want 0", r_ready_after); end
    do_req(1'b0, 1'b0, 32'h10, 32'h0);
    checks++; if (r_edges !== 3) begin errors++; $display("FAIL word_ld_latency: got %0d want 3", r_edges); end
    checks++; if (r_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL word_ld_data: got %h want %h", r_rdata, 32'hDEADBEEF); end
    checks++; if (r_err !== 1'b0) begin errors++; $display("FAIL word_ld_err: got %b want 0", r_err); end
  endtask

  task automatic test_byte;
    do_req(1'b1, 1'b0, 32'h10, 32'h11223344);
    checks++; if (r_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL store_keeps_rdata: got %h want %h", r_rdata, 32'hDEADBEEF); end
    do_req(1'b1, 1'b1, 32'h13, 32'hFFFFFFA5);
    checks++; if (r_err !== 1'b0) begin errors++; $display("FAIL byte_st_err: got %b want 0", r_err); end
    do_req(1'b0, 1'b0, 32'h10, 32'h0);
    checks++; if (r_rdata !== 32'hA5223344) begin errors++; $display("FAIL byte_merge: got %h want %h", r_rdata, 32'hA5223344); end
    do_req(1'b0, 1'b1, 32'h13, 32'h0);
    checks++; if (r_rdata !== 32'h000000A5) begin errors++; $display("FAIL byte_ld_lane3: got %h want %h", r_rdata, 32'h000000A5); end
    do_req(1'b0, 1'b1, 32'h12, 32'h0);
    checks++; if (r_rdata !== 32'h00000022) begin errors++; $display("FAIL byte_ld_lane2: got %h want %h", r_rdata, 32'h00000022); end
    do_req(1'b0, 1'b1, 32'h10, 32'h0);
    checks++; if (r_rdata !== 32'h00000044) begin errors++; $display("FAIL byte_ld_lane0: got %h want %h", r_rdata, 32'h00000044); end
  endtask

  task automatic test_misaligned;
    do_req(1'b1, 1'b0, 32'h20, 32'h55667788);
    do_req(1'b0, 1'b0, 32'h22, 32'h0);
    checks++; if (r_err !== 1'b1) begin errors++; $display("FAIL misal_ld_err: got %b want 1", r_err); end
    checks++; if (r_rdata !== 32'd0) begin errors++; $display("FAIL misal_ld_data: got %h want %h", r_rdata, 32'd0); end
    checks++; if (r_edges !== 3) begin errors++; $display("FAIL misal_ld_latency: got %0d want 3", r_edges); end
    do_req(1'b1, 1'b0, 32'h22, 32'hFFFFFFFF);
    checks++; if (r_err !== 1'b1) begin errors++; $display("FAIL misal_st_err: got %b want 1", r_err); end
    do_req(1'b0, 1'b0, 32'h20, 32'h0);
    checks++; if (r_rdata !== 32'h55667788) begin errors++; $display("FAIL misal_no_write: got %h want %h", r_rdata, 32'h55667788); end
    checks++; if (r_err !== 1'b0) begin errors++; $display("FAIL aligned_err_clear: got %b want 0", r_err); end
    do_req(1'b0, 1'b1, 32'h21, 32'h0);
    checks++; if (r_err !== 1'b0) begin errors++; $display("FAIL byte_odd_err: got %b want 0", r_err); end
    checks++; if (r_rdata !== 32'h00000077) begin errors++; $display("FAIL byte_odd_data: got %h want %h", r_rdata, 32'h00000077); end
  endtask

  task automatic test_alias;
    do_req(1'b1, 1'b0, 32'h100, 32'h12345678);
    do_req(1'b0, 1'b0, 32'h000, 32'h0);
    checks++; if (r_rdata !== 32'h12345678) begin errors++; $display("FAIL alias_ld: got %h want %h", r_rdata, 32'h12345678); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_busy;
    logic [7:0] exp_ready;
    exp_busy  = 8'b0111_0111;
    exp_ready = 8'b0100_0100;
    @(negedge clk);
    MemReq = 1'b1; MemWrite = 1'b0; ByteMode = 1'b0; Addr = 32'h10; WriteData = 32'h0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      checks++; if (Busy !== exp_busy[i]) begin errors++; $display("FAIL b2b_busy[%0d]: got %b want %b", i, Busy, exp_busy[i]); end
      checks++; if (MemReady !== exp_ready[i]) begin errors++; $display("FAIL b2b_ready[%0d]: got %b want %b", i, MemReady, exp_ready[i]); end
      if (exp_ready[i]) begin
        checks++; if (ReadData !== 32'hA5223344) begin errors++; $display("FAIL b2b_data[%0d]: got %h want %h", i, ReadData, 32'hA5223344); end
      end
    end
    @(negedge clk);
    MemReq = 1'b0;
    @(posedge clk); #1;
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_after: got %b want 0", Busy); end
  endtask

  task automatic test_reset_abort;
    int seen_ready;
    do_req(1'b1, 1'b0, 32'h08, 32'h00000000);
    @(negedge clk);
    MemReq = 1'b1; MemWrite = 1'b1; ByteMode = 1'b0; Addr = 32'h08; WriteData = 32'hCAFEF00D;
    @(posedge clk); #1;
    MemReq = 1'b0;
    checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL abort_accepted: got %b want 1", Busy); end
    @(posedge clk); #1;
    checks++; if (ReadData !== 32'hA5223344) begin errors++; $display("FAIL abort_pre_rdata: got %h want %h", ReadData, 32'hA5223344); end
    reset = 1'b1;
    #1;
    checks++; if (ReadData !== 32'd0) begin errors++; $display("FAIL abort_rdata: got %h want %h", ReadData, 32'd0); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", Busy); end
    checks++; if (MemReady !== 1'b0) begin errors++; $display("FAIL abort_ready: got %b want 0", MemReady); end
    checks++; if (MemErr !== 1'b0) begin errors++; $display("FAIL abort_err: got %b want 0", MemErr); end
    seen_ready = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (i == 2) reset = 1'b0;
      if (MemReady === 1'b1) seen_ready++;
    end
    checks++; if (seen_ready !== 0) begin errors++; $display("FAIL abort_no_resp: got %0d want 0", seen_ready); end
    do_req(1'b0, 1'b0, 32'h08, 32'h0);
    checks++; if (r_rdata !== 32'h00000000) begin errors++; $display("FAIL abort_no_write: got %h want %h", r_rdata, 32'h0); end
    checks++; if (r_edges !== 3) begin errors++; $display("FAIL abort_recover_latency: got %0d want 3", r_edges); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_misaligned();
    test_alias();
    test_back_to_back();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH, 64, number of 32-bit words stored (power of two, 4..1024).
REQ-002 SHALL have parameter WAIT_CYCLES, 2, wait states inserted before each response (0..15).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port MemReq  input  1  access request valid.
REQ-006 SHALL have port MemWrite  input  1  1 = store, 0 = load; qualified by MemReq.
REQ-007 SHALL have port ByteMode  input  1  1 = byte access (LDRB/STRB), 0 = word access.
REQ-008 SHALL have port Addr  input  32  byte address from the core ALU result.
REQ-009 SHALL have port WriteData  input  32  store data.
REQ-010 SHALL have port ReadData  output  32  registered load data.
REQ-011 SHALL have port MemReady  output  1  one-cycle response strobe.
REQ-012 SHALL have port MemErr  output  1  error flag, valid only while MemReady=1.
REQ-013 SHALL have port Busy  output  1  high whenever a request is in progress (state != IDLE).

Function
REQ-014 SHALL implement a three-state FSM: IDLE, WAIT, RESP.
REQ-015 IDLE with MemReq=1 SHALL accept: latch Addr, WriteData, MemWrite, ByteMode, load wait counter with WAIT_CYCLES, go to WAIT (or RESP directly if WAIT_CYCLES=0).
REQ-016 WAIT SHALL decrement the counter each edge; on the edge where counter equals 1, go to RESP.
REQ-017 RESP SHALL last exactly one cycle with MemReady=1, then return to IDLE unconditionally.
REQ-018 MemReady SHALL rise exactly WAIT_CYCLES+1 edges after the accepting edge.
REQ-019 MemReq SHALL be ignored in WAIT and RESP; no queuing; next accept earliest in the IDLE cycle after RESP.
REQ-020 Word index SHALL be latched Addr[log2(DEPTH)+1:2]; higher address bits ignored (aliasing wrap-around).
REQ-021 Word access with Addr[1:0] != 0 SHALL be an error: MemErr=1 in RESP, no array write, ReadData=0.
REQ-022 Array write and ReadData update SHALL both occur on the edge entering RESP.
REQ-023 Word store SHALL write all 32 bits; byte store SHALL write WriteData[7:0] into lane Addr[1:0] (lane 0 = bits 7:0, little-endian), other lanes unchanged.
REQ-024 Word load SHALL return the stored word; byte load SHALL return the addressed lane zero-extended to 32 bits.
REQ-025 Store responses SHALL leave ReadData unchanged; ReadData SHALL hold between responses.
REQ-026 Load and store to the same word SHALL be strictly ordered by acceptance; a load after a store returns the stored data.
REQ-027 Byte accesses SHALL never raise MemErr.

Reset
REQ-028 reset=1 SHALL immediately force state IDLE, counter 0, ReadData=0, MemReady=0, MemErr=0, Busy=0.
REQ-029 Reset during WAIT SHALL abort the request with no array write and no response.
REQ-030 Array contents SHALL NOT be cleared by reset and are undefined until written.

Verification
REQ-031 WAIT_CYCLES=2: word store 0xDEADBEEF at 0x10, then word load 0x10 -> each MemReady rises 3 edges after acceptance, load returns 0xDEADBEEF, MemErr=0.
REQ-032 Byte store 0xA5 at 0x13 over word 0x11223344 at 0x10, then word load 0x10 -> 0xA5223344; byte load 0x13 -> 0x000000A5.
REQ-033 Word load at 0x22 -> MemErr=1, ReadData=0; word at 0x20 unchanged by a word store to 0x22.
REQ-034 DEPTH=64: store 0x12345678 at 0x100, load at 0x000 -> 0x12345678 (alias).
REQ-035 MemReq held high throughout two requests -> second accepted only in the IDLE cycle after RESP; Busy=1 for WAIT and RESP cycles only.
REQ-036 Assert reset one edge after accepting a store of 0xCAFEF00D at 0x08 over prior 0x0 -> outputs zero immediately, no MemReady, later load of 0x08 returns 0x0.
